// File: rtl/pc_redirect_ctrl_pkg.sv
// rtl/pc_redirect_ctrl_pkg.sv - shared pipeline constants, redirect FSM state encoding
//
// Purpose: common definitions for the PC/IF-stage control path.
//   XLEN_DEFAULT         default PC/target bus width
//   PC_INC               sequential PC increment
//   LOAD_USE_HOLD_CYCLES hazard-unit hold length for a load-use stall
//   FLUSH_CNT_W          width of the post-redirect bubble counter
//   redirect_state_e     RUN / FLUSH / HALT / RESUME, 2-bit encoding
package pc_redirect_ctrl_pkg;

  localparam int unsigned XLEN_DEFAULT         = 32;
  localparam int unsigned PC_INC               = 4;
  localparam int unsigned LOAD_USE_HOLD_CYCLES = 1;
  localparam int unsigned FLUSH_CNT_W          = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_FLUSH  = 2'b01,
    ST_HALT   = 2'b10,
    ST_RESUME = 2'b11
  } redirect_state_e;

endpackage

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// rtl/pc_redirect_ctrl_sat_counter.sv - saturating event counter
//
// Purpose: counts single-cycle events, sticks at all-ones.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset, clears the count
//   inc_i    count this cycle
//   count_o  current count
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - PC redirect / flush / halt controller
//
// Purpose: arbitrates branch, JALR, load-use and system-halt events into
// PC-register and IF/ID-register control, parks the core on ECALL/EBREAK
// and restarts it at EPC+4 on a resume pulse.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   load_use_i          hazard unit one-cycle hold request
//   branch_taken_i      ID branch taken, target in branch_target_i
//   jalr_req_i          ID JALR, raw target in jalr_target_i
//   sys_halt_i          system instruction retiring, its PC in sys_pc_i
//   resume_i            one-cycle release pulse
//   pc_stall_o          PC load disable
//   if_flush_o          zero IF/ID
//   redirect_valid_o    PC loads redirect_pc_o this cycle
//   redirect_pc_o       redirect address
//   halted_o            parked in HALT
//   redirect_cnt_o      saturating count of redirects
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_use_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            jalr_req_i,
  input  logic [XLEN-1:0] jalr_target_i,
  input  logic            sys_halt_i,
  input  logic [XLEN-1:0] sys_pc_i,
  input  logic            resume_i,
  output logic            pc_stall_o,
  output logic            if_flush_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            halted_o,
  output logic [15:0]     redirect_cnt_o
);

  // The redirect cycle itself is the first bubble, so the counter only
  // covers the remaining FLUSH_CYCLES-1 cycles spent in FLUSH.
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic                   USE_FLUSH  = (FLUSH_CYCLES > 1);

  redirect_state_e        state_q, state_d;
  logic [XLEN-1:0]        epc_q;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic                   epc_load;
  logic [15:0]            redirect_cnt;

  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    epc_load         = 1'b0;
    pc_stall_o       = 1'b0;
    if_flush_o       = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    halted_o         = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (sys_halt_i) begin
          epc_load   = 1'b1;
          pc_stall_o = 1'b1;
          if_flush_o = 1'b1;
          state_d    = ST_HALT;
        end else if (jalr_req_i || branch_taken_i) begin
          redirect_valid_o = 1'b1;
          if_flush_o       = 1'b1;
          redirect_pc_o    = jalr_req_i ? {jalr_target_i[XLEN-1:1], 1'b0}
                                        : branch_target_i;
          flush_cnt_d      = FLUSH_LOAD;
          state_d          = USE_FLUSH ? ST_FLUSH : ST_RUN;
        end else if (load_use_i) begin
          pc_stall_o = 1'b1;
        end
      end
      ST_FLUSH: begin
        if_flush_o = 1'b1;
        if (sys_halt_i) begin
          epc_load   = 1'b1;
          pc_stall_o = 1'b1;
          state_d    = ST_HALT;
        end else begin
          flush_cnt_d = (flush_cnt_q == '0) ? '0 : flush_cnt_q - FLUSH_CNT_W'(1);
          // Leave on the cycle that consumes the last bubble.
          if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_HALT: begin
        pc_stall_o = 1'b1;
        if_flush_o = 1'b1;
        halted_o   = 1'b1;
        if (resume_i) begin
          state_d = ST_RESUME;
        end
      end
      ST_RESUME: begin
        redirect_valid_o = 1'b1;
        if_flush_o       = 1'b1;
        redirect_pc_o    = epc_q + XLEN'(PC_INC);
        state_d          = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Reset dominates: nothing leaks out while it is held.
    if (rst_i) begin
      epc_load         = 1'b0;
      pc_stall_o       = 1'b0;
      if_flush_o       = 1'b0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
      halted_o         = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      epc_q       <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      if (epc_load) begin
        epc_q <= sys_pc_i;
      end
    end
  end

  sat_counter #(
    .WIDTH (16)
  ) u_redirect_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (redirect_valid_o),
    .count_o (redirect_cnt)
  );

  assign redirect_cnt_o = rst_i ? 16'h0000 : redirect_cnt;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        lu, bt, jr, sh, rs;
  logic [31:0] btgt, jtgt, spc;

  logic        stall1, flush1, rv1, halt1;
  logic [31:0] rpc1;
  logic [15:0] cnt1;
  logic        stall3, flush3, rv3, halt3;
  logic [31:0] rpc3;
  logic [15:0] cnt3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(1)) d1 (
    .clk_i(clk), .rst_i(rst), .load_use_i(lu), .branch_taken_i(bt),
    .branch_target_i(btgt), .jalr_req_i(jr), .jalr_target_i(jtgt),
    .sys_halt_i(sh), .sys_pc_i(spc), .resume_i(rs),
    .pc_stall_o(stall1), .if_flush_o(flush1), .redirect_valid_o(rv1),
    .redirect_pc_o(rpc1), .halted_o(halt1), .redirect_cnt_o(cnt1)
  );

  pc_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(3)) d3 (
    .clk_i(clk), .rst_i(rst), .load_use_i(lu), .branch_taken_i(bt),
    .branch_target_i(btgt), .jalr_req_i(jr), .jalr_target_i(jtgt),
    .sys_halt_i(sh), .sys_pc_i(spc), .resume_i(rs),
    .pc_stall_o(stall3), .if_flush_o(flush3), .redirect_valid_o(rv3),
    .redirect_pc_o(rpc3), .halted_o(halt3), .redirect_cnt_o(cnt3)
  );

  typedef struct {
    logic        lu;
    logic        bt;
    logic [31:0] btgt;
    logic        jr;
    logic [31:0] jtgt;
    logic        e_stall;
    logic        e_flush;
    logic        e_rv;
    logic [31:0] e_rpc;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    lu = 0; bt = 0; jr = 0; sh = 0; rs = 0;
    btgt = '0; jtgt = '0; spc = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    clr();
    step();
    rst = 0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            lu bt  btgt          jr  jtgt          st fl rv  rpc           cnt
    tbl[0] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        16'd0};
    tbl[1] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        16'd0};
    tbl[2] = '{1'b0, 1'b1, 32'h100,      1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h100,      16'd0};
    tbl[3] = '{1'b1, 1'b1, 32'h100,      1'b1, 32'h203,      1'b0, 1'b1, 1'b1, 32'h202,      16'd1};
    tbl[4] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h1001,     1'b0, 1'b1, 1'b1, 32'h1000,     16'd2};
    tbl[5] = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 16'd3};
    tbl[6] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFE, 16'd4};
    tbl[7] = '{1'b1, 1'b0, 32'h55,       1'b0, 32'h77,       1'b1, 1'b0, 1'b0, 32'h0,        16'd5};

    // Reset holds all outputs low even with events present.
    rst = 1; clr(); bt = 1; btgt = 32'h100; sh = 1; lu = 1;
    #1;
    chk("rst_stall1", stall1, 0); chk("rst_flush1", flush1, 0);
    chk("rst_rv1", rv1, 0); chk("rst_rpc1", rpc1, 0);
    chk("rst_halt1", halt1, 0); chk("rst_rv3", rv3, 0);
    step();
    chk("rst_cnt1", cnt1, 0);
    rst = 0; clr();

    // Table: single-cycle behaviour in RUN, FLUSH_CYCLES=1 instance.
    for (int i = 0; i < 8; i++) begin
      lu = tbl[i].lu; bt = tbl[i].bt; btgt = tbl[i].btgt;
      jr = tbl[i].jr; jtgt = tbl[i].jtgt;
      #1;
      chk($sformatf("v%0d_stall", i), stall1, tbl[i].e_stall);
      chk($sformatf("v%0d_flush", i), flush1, tbl[i].e_flush);
      chk($sformatf("v%0d_rv", i), rv1, tbl[i].e_rv);
      chk($sformatf("v%0d_rpc", i), rpc1, tbl[i].e_rpc);
      chk($sformatf("v%0d_cnt", i), cnt1, 32'(tbl[i].e_cnt));
      step();
    end
    clr(); #1;
    chk("tbl_cnt_final", cnt1, 5);

    // Simultaneous events, 3-cycle flush; branch ignored while flushing.
    do_reset();
    jr = 1; jtgt = 32'h203; bt = 1; btgt = 32'h100; lu = 1;
    #1;
    chk("sim_rv3", rv3, 1); chk("sim_rpc3", rpc3, 32'h202);
    chk("sim_stall3", stall3, 0); chk("sim_flush3", flush3, 1);
    step(); jr = 0;
    for (int c = 2; c <= 3; c++) begin
      #1;
      chk($sformatf("fl%0d_flush3", c), flush3, 1);
      chk($sformatf("fl%0d_rv3", c), rv3, 0);
      chk($sformatf("fl%0d_stall3", c), stall3, 0);
      step();
    end
    btgt = 32'h300; #1;
    chk("fl_done_rv3", rv3, 1); chk("fl_done_rpc3", rpc3, 32'h300);
    clr();

    // Halt / idle / resume.
    do_reset();
    sh = 1; spc = 32'h40; #1;
    chk("h0_stall", stall1, 1); chk("h0_flush", flush1, 1);
    chk("h0_halt", halt1, 0); chk("h0_rv", rv1, 0);
    step(); sh = 0; bt = 1; jr = 1; lu = 1; btgt = 32'h500; jtgt = 32'h600; #1;
    chk("h1_halt", halt1, 1); chk("h1_stall", stall1, 1); chk("h1_flush", flush1, 1);
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("idle%0d_halt", k), halt1, 1);
      chk($sformatf("idle%0d_rv", k), rv1, 0);
    end
    rs = 1; #1;
    chk("rsp_halt", halt1, 1);
    step(); clr(); #1;
    chk("res_rv", rv1, 1); chk("res_rpc", rpc1, 32'h44);
    chk("res_flush", flush1, 1); chk("res_stall", stall1, 0); chk("res_halt", halt1, 0);
    step(); lu = 1; #1;
    chk("run_stall", stall1, 1); chk("run_flush", flush1, 0); chk("run_cnt", cnt1, 1);
    clr();

    // sys_halt preempts FLUSH; reset abandons HALT.
    do_reset();
    bt = 1; btgt = 32'h100; #1;
    chk("pre_rv3", rv3, 1);
    step(); sh = 1; spc = 32'h80; #1;
    chk("pre_stall3", stall3, 1); chk("pre_rv3b", rv3, 0); chk("pre_halt3", halt3, 0);
    step(); clr(); #1;
    chk("pre_halted3", halt3, 1);
    rs = 1; step(); rs = 0; #1;
    chk("pre_res_rv3", rv3, 1); chk("pre_res_rpc3", rpc3, 32'h84);
    step(); bt = 1; #1;
    step(); bt = 0; sh = 1; spc = 32'h90;
    step(); clr(); #1;
    chk("pre2_halted3", halt3, 1);
    rst = 1; #1;
    chk("rh_halt3", halt3, 0); chk("rh_stall3", stall3, 0);
    chk("rh_flush3", flush3, 0); chk("rh_rv3", rv3, 0);
    chk("rh_rpc3", rpc3, 0); chk("rh_cnt3", cnt3, 0);
    step(); rst = 0; #1;
    chk("ar_halt3", halt3, 0); chk("ar_stall3", stall3, 0);
    chk("ar_flush3", flush3, 0); chk("ar_cnt3", cnt3, 0);
    step();
    chk("ar2_rv3", rv3, 0); chk("ar2_flush3", flush3, 0);

    // EPC+4 wraps.
    do_reset();
    sh = 1; spc = 32'hFFFFFFFC;
    step(); clr(); rs = 1;
    step(); rs = 0; #1;
    chk("wrap_rv", rv1, 1); chk("wrap_rpc", rpc1, 32'h0);

    // Counter saturation.
    do_reset();
    bt = 1; btgt = 32'h10;
    repeat (65534) step();
    chk("sat_fffe", cnt1, 32'hFFFE);
    step();
    chk("sat_ffff", cnt1, 32'hFFFF);
    repeat (2) step();
    chk("sat_hold", cnt1, 32'hFFFF);
    clr();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
